rv32i_instr_encoder: RTL and testbench
======================================

Name: rv32i_instr_encoder

Overview:
- Inverse of the core's control decoder: takes a symbolic instruction (mnemonic code, register indices, immediate) and emits the 32-bit RV32I machine word.
- Covers the same instruction subset the single-cycle core executes.
- Emits each word with its instruction-memory byte address, so a test harness or boot loader can stream programs into IM.
- Valid/ready on both sides, one registered output stage, address counter, immediate range checking with error reporting.

Parameters:
- ADDR_W, 32, width of out_addr; wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, out_addr value after reset and after clear.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous; reloads the address counter, drops the output entry, zeroes instr_count.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_mnem  in  5  0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 addi, 11 xori, 12 ori, 13 andi, 14 slti, 15 sltiu, 16 lw, 17 sw, 18 beq, 19 lui, 20 jal; 21-31 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices; unused fields ignored.
- in_imm  in  32  signed immediate/offset in bytes. For lui, the unsigned 20-bit upper value.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  IM byte address of out_instr.
- err_valid  out  1  one-cycle pulse: the accepted request was rejected.
- err_code  out  2  1 illegal mnemonic, 2 immediate out of range, 3 misaligned branch/jump offset; holds last value.
- instr_count  out  16  words handed off since reset/clear; wraps.

Behaviour:
- Reset (rstn low, immediate):
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR.
  - err_valid=0, err_code=0, instr_count=0.
- Handshake:
  - in_ready = ~out_valid | out_ready, combinational. Full throughput, one word per cycle.
  - Latency: a request accepted in cycle N gives out_valid in cycle N+1.
  - While out_valid & ~out_ready, out_instr and out_addr hold stable.
- Output accept (out_valid & out_ready):
  - out_addr += 4, instr_count += 1.
  - If a new legal request is accepted in the same cycle, it loads into the register at the incremented address.
- Rejected request (illegal mnemonic or bad immediate):
  - Still consumes the handshake. No word is emitted and the address does not advance.
  - err_valid=1 the next cycle; err_code updated.
  - out_valid still drops if the previous word is accepted in that cycle.
- Check priority: illegal (1) > range (2) > alignment (3).
- Immediate ranges:
  - I/S types: -2048..2047.
  - beq: -4096..4094.
  - jal: -1048576..1048574.
  - lui: 0..0xFFFFF.
  - Shifts are R-type only, so no shamt check.
- Alignment: beq/jal offset bit0 must be 0.
- Encodings (fields MSB to LSB):
  - R: funct7|rs2|rs1|funct3|rd|0110011. funct7=0100000 for sub/sra, else 0. funct3: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111.
  - I-alu: imm[11:0]|rs1|funct3|rd|0010011. funct3: addi 000, slti 010, sltiu 011, xori 100, ori 110, andi 111.
  - lw: imm[11:0]|rs1|010|rd|0000011.
  - sw: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - beq: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
  - lui: imm[19:0]|rd|0110111.
  - jal: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
- clear:
  - out_valid=0, out_addr=BASE_ADDR, instr_count=0; err_code kept.
  - in_ready=0 that cycle; clear wins over any simultaneous handshake.
- Address wrap: from 2^ADDR_W-4 to 0, silently.

Test Plan:
- Reset, then add rd=3,rs1=1,rs2=2 with out_ready=1 -> next cycle out_instr=0x002081B3, out_addr=0; then instr_count=1.
- Back-to-back stream, out_ready=1, one per cycle:
  - addi x1,x0,-1 -> 0xFFF00093
  - sw x2,8(x1) -> 0x0020A423
  - beq x1,x2,-4 -> 0xFE208EE3
  - jal x1,8 -> 0x008000EF
  - lui x5,0x12345 -> 0x123452B7
  - Required: addresses 0,4,8,12,16; no bubbles.
- Backpressure: out_ready=0 for 3 cycles with a word pending -> in_ready=0, out_instr/out_addr stable; release -> word taken, next request accepted the same cycle.
- Errors:
  - addi imm=2048 -> err_valid pulse, err_code=2.
  - beq imm=6... wait, 6 is even; use beq imm=5 -> err_code=3.
  - in_mnem=25 -> err_code=1.
  - Required for all: no out_valid, out_addr unchanged.
- clear asserted with a pending word and a simultaneous in_valid -> out_valid=0, out_addr=BASE_ADDR, request not accepted; rstn pulsed mid-stream -> all outputs at reset values immediately.
- ADDR_W=4, BASE_ADDR=8: emit 3 words -> addresses 8, 12, 0.

Source files
------------

// File: rtl/rv32i_instr_encoder.sv
// Symbolic RV32I instruction -> machine word encoder with IM address tagging.
// One registered output stage (1-cycle latency); in_ready = ~out_valid | out_ready.
module rv32i_instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [15:0]       instr_count
);

  typedef enum logic [4:0] {
    M_ADD  = 5'd0,  M_SUB   = 5'd1,  M_XOR  = 5'd2,  M_OR   = 5'd3,
    M_AND  = 5'd4,  M_SLL   = 5'd5,  M_SRL  = 5'd6,  M_SRA  = 5'd7,
    M_SLT  = 5'd8,  M_SLTU  = 5'd9,  M_ADDI = 5'd10, M_XORI = 5'd11,
    M_ORI  = 5'd12, M_ANDI  = 5'd13, M_SLTI = 5'd14, M_SLTIU = 5'd15,
    M_LW   = 5'd16, M_SW    = 5'd17, M_BEQ  = 5'd18, M_LUI  = 5'd19,
    M_JAL  = 5'd20
  } mnem_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE= 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [15:0]       count_q, count_d;

  logic [31:0]       enc;
  logic [1:0]        chk_code;
  logic              illegal, range_bad, misalign;
  logic signed [31:0] simm;
  logic              accept_in, out_fire, load;

  assign simm = $signed(in_imm);

  // Checks in priority order: illegal mnemonic, then range, then alignment.
  always_comb begin
    illegal   = (in_mnem > M_JAL);
    range_bad = 1'b0;
    misalign  = 1'b0;
    if (!illegal) begin
      if (in_mnem >= M_ADDI && in_mnem <= M_SW) begin
        range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      end else if (in_mnem == M_BEQ) begin
        range_bad = (simm < -32'sd4096) || (simm > 32'sd4094);
        misalign  = in_imm[0];
      end else if (in_mnem == M_JAL) begin
        range_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574);
        misalign  = in_imm[0];
      end else if (in_mnem == M_LUI) begin
        range_bad = (in_imm[31:20] != 12'd0);
      end
    end
    if (illegal)        chk_code = 2'd1;
    else if (range_bad) chk_code = 2'd2;
    else if (misalign)  chk_code = 2'd3;
    else                chk_code = 2'd0;
  end

  always_comb begin
    enc = 32'd0;
    case (in_mnem)
      M_ADD:   enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
      M_SUB:   enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
      M_SLL:   enc = {7'b0000000, in_rs2, in_rs1, 3'b001, in_rd, OP_R};
      M_SLT:   enc = {7'b0000000, in_rs2, in_rs1, 3'b010, in_rd, OP_R};
      M_SLTU:  enc = {7'b0000000, in_rs2, in_rs1, 3'b011, in_rd, OP_R};
      M_XOR:   enc = {7'b0000000, in_rs2, in_rs1, 3'b100, in_rd, OP_R};
      M_SRL:   enc = {7'b0000000, in_rs2, in_rs1, 3'b101, in_rd, OP_R};
      M_SRA:   enc = {7'b0100000, in_rs2, in_rs1, 3'b101, in_rd, OP_R};
      M_OR:    enc = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OP_R};
      M_AND:   enc = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OP_R};
      M_ADDI:  enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_I};
      M_SLTI:  enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_I};
      M_SLTIU: enc = {in_imm[11:0], in_rs1, 3'b011, in_rd, OP_I};
      M_XORI:  enc = {in_imm[11:0], in_rs1, 3'b100, in_rd, OP_I};
      M_ORI:   enc = {in_imm[11:0], in_rs1, 3'b110, in_rd, OP_I};
      M_ANDI:  enc = {in_imm[11:0], in_rs1, 3'b111, in_rd, OP_I};
      M_LW:    enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
      M_SW:    enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
      M_BEQ:   enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                      in_imm[4:1], in_imm[11], OP_BR};
      M_LUI:   enc = {in_imm[19:0], in_rd, OP_LUI};
      M_JAL:   enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      default: enc = 32'd0;
    endcase
  end

  // clear blocks the input handshake so a simultaneous request is never lost silently.
  assign in_ready  = ~clear & (~out_valid_q | out_ready);
  assign accept_in = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign load      = accept_in & (chk_code == 2'd0);

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    addr_d      = addr_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    count_d     = count_q;
    if (clear) begin
      out_valid_d = 1'b0;
      addr_d      = BASE_ADDR;
      count_d     = 16'd0;
    end else begin
      if (out_fire) begin
        addr_d  = addr_q + ADDR_W'(4);
        count_d = count_q + 16'd1;
      end
      out_valid_d = load | (out_valid_q & ~out_ready);
      if (load) out_instr_d = enc;
      if (accept_in && chk_code != 2'd0) begin
        err_valid_d = 1'b1;
        err_code_d  = chk_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      addr_q      <= BASE_ADDR;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
      count_q     <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      addr_q      <= addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      count_q     <= count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_addr    = addr_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Bench for rv32i_instr_encoder: vector table plus scoreboard queues, and
// hand sequences for backpressure, clear, mid-run reset and address wrap.
module tb_rv32i_instr_encoder;

  typedef struct {
    logic [4:0]  mnem;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [1:0]  err;
    logic [31:0] instr;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_mnem = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] instr_count;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic        out_valid2;
  logic        out_ready2 = 1'b0;
  logic [31:0] out_instr2;
  logic [3:0]  out_addr2;
  logic        err_valid2;
  logic [1:0]  err_code2;
  logic [15:0] instr_count2;

  int total = 0;
  int bad = 0;
  int stalls = 0;
  logic [31:0] model_addr = 32'd0;
  exp_t word_q[$];
  logic [1:0] err_q[$];

  always #5 clk = ~clk;

  rv32i_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'd0)) u_dut (
    .clk(clk), .rstn(rstn), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_valid(err_valid), .err_code(err_code), .instr_count(instr_count)
  );

  rv32i_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd8)) u_dut_wrap (
    .clk(clk), .rstn(rstn), .clear(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_mnem(5'd10), .in_rd(5'd1), .in_rs1(5'd0), .in_rs2(5'd0), .in_imm(32'hFFFF_FFFF),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2), .out_addr(out_addr2),
    .err_valid(err_valid2), .err_code(err_code2), .instr_count(instr_count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // Words are popped the cycle they are handed off; errors when the pulse appears.
  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid && out_ready) begin
        if (word_q.size() == 0) begin
          chk("word_unexpected", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = word_q.pop_front();
          chk("word_instr", out_instr, e.instr);
          chk("word_addr", out_addr, e.addr);
        end
      end
      if (err_valid) begin
        if (err_q.size() == 0) begin
          chk("err_unexpected", 32'd0, 32'd1);
        end else begin
          logic [1:0] c;
          c = err_q.pop_front();
          chk("err_code", {30'd0, err_code}, {30'd0, c});
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_mnem  = v.mnem;
    in_rd    = v.rd;
    in_rs1   = v.rs1;
    in_rs2   = v.rs2;
    in_imm   = v.imm;
  endtask

  // Call #1 after a rising edge; returns #1 after the edge that took the request.
  task automatic send(input vec_t v);
    int w;
    drive(v);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (v.err == 2'd0) begin
        word_q.push_back('{instr: v.instr, addr: model_addr});
        model_addr = model_addr + 32'd4;
      end else begin
        err_q.push_back(v.err);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("drain_words", word_q.size(), 32'd0);
    chk("drain_errs", err_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[27];
  vec_t strm[5];
  vec_t errs[3];
  vec_t v_add, v_a, v_b, v_c;
  logic [31:0] a_addr;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{5'd0,  5'd3,  5'd1,  5'd2,  32'd0,        2'd0, 32'h002081B3};
    tbl[1]  = '{5'd1,  5'd5,  5'd6,  5'd7,  32'd0,        2'd0, 32'h407302B3};
    tbl[2]  = '{5'd7,  5'd10, 5'd11, 5'd12, 32'd0,        2'd0, 32'h40C5D533};
    tbl[3]  = '{5'd9,  5'd1,  5'd2,  5'd3,  32'd0,        2'd0, 32'h003130B3};
    tbl[4]  = '{5'd4,  5'd31, 5'd31, 5'd31, 32'd0,        2'd0, 32'h01FFFFB3};
    tbl[5]  = '{5'd5,  5'd1,  5'd2,  5'd3,  32'd12345,    2'd0, 32'h003110B3};
    tbl[6]  = '{5'd6,  5'd1,  5'd2,  5'd3,  32'd0,        2'd0, 32'h003150B3};
    tbl[7]  = '{5'd2,  5'd1,  5'd2,  5'd3,  32'd0,        2'd0, 32'h003140B3};
    tbl[8]  = '{5'd3,  5'd1,  5'd2,  5'd3,  32'd0,        2'd0, 32'h003160B3};
    tbl[9]  = '{5'd8,  5'd1,  5'd2,  5'd3,  32'd0,        2'd0, 32'h003120B3};
    tbl[10] = '{5'd13, 5'd4,  5'd5,  5'd0,  32'd2047,     2'd0, 32'h7FF2F213};
    tbl[11] = '{5'd14, 5'd6,  5'd7,  5'd0,  -32'sd2048,   2'd0, 32'h8003A313};
    tbl[12] = '{5'd11, 5'd1,  5'd2,  5'd0,  32'hFFFFFFFF, 2'd0, 32'hFFF14093};
    tbl[13] = '{5'd12, 5'd1,  5'd2,  5'd0,  32'd1,        2'd0, 32'h00116093};
    tbl[14] = '{5'd15, 5'd1,  5'd2,  5'd0,  32'd5,        2'd0, 32'h00513093};
    tbl[15] = '{5'd16, 5'd8,  5'd2,  5'd0,  32'd4,        2'd0, 32'h00412403};
    tbl[16] = '{5'd17, 5'd0,  5'd4,  5'd3,  32'hFFFFFFFF, 2'd0, 32'hFE322FA3};
    tbl[17] = '{5'd18, 5'd0,  5'd0,  5'd0,  32'd4094,     2'd0, 32'h7E000FE3};
    tbl[18] = '{5'd20, 5'd0,  5'd0,  5'd0,  -32'sd1048576, 2'd0, 32'h8000006F};
    tbl[19] = '{5'd19, 5'd1,  5'd0,  5'd0,  32'h000FFFFF, 2'd0, 32'hFFFFF0B7};
    tbl[20] = '{5'd10, 5'd1,  5'd0,  5'd0,  -32'sd2049,   2'd2, 32'h0};
    tbl[21] = '{5'd18, 5'd0,  5'd1,  5'd2,  32'd4095,     2'd2, 32'h0};
    tbl[22] = '{5'd20, 5'd1,  5'd0,  5'd0,  32'd3,        2'd3, 32'h0};
    tbl[23] = '{5'd20, 5'd1,  5'd0,  5'd0,  32'd1048576,  2'd2, 32'h0};
    tbl[24] = '{5'd19, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFF, 2'd2, 32'h0};
    tbl[25] = '{5'd21, 5'd1,  5'd0,  5'd0,  32'd99999999, 2'd1, 32'h0};
    tbl[26] = '{5'd17, 5'd0,  5'd1,  5'd2,  32'd2048,     2'd2, 32'h0};

    strm[0] = '{5'd10, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 2'd0, 32'hFFF00093};
    strm[1] = '{5'd17, 5'd0, 5'd1, 5'd2, 32'd8,        2'd0, 32'h0020A423};
    strm[2] = '{5'd18, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 2'd0, 32'hFE208EE3};
    strm[3] = '{5'd20, 5'd1, 5'd0, 5'd0, 32'd8,        2'd0, 32'h008000EF};
    strm[4] = '{5'd19, 5'd5, 5'd0, 5'd0, 32'h00012345, 2'd0, 32'h123452B7};

    errs[0] = '{5'd10, 5'd1, 5'd0, 5'd0, 32'd2048, 2'd2, 32'h0};
    errs[1] = '{5'd18, 5'd0, 5'd1, 5'd2, 32'd5,    2'd3, 32'h0};
    errs[2] = '{5'd25, 5'd1, 5'd0, 5'd0, 32'd0,    2'd1, 32'h0};

    v_add = tbl[0];
    v_a   = tbl[19];
    v_b   = tbl[1];
    v_c   = tbl[15];

    // Reset values while rstn is low
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    chk("rst_instr_count", {16'd0, instr_count}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Single add, then instr_count after hand-off
    send(v_add);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("first_count", {16'd0, instr_count}, 32'd1);
    chk("first_next_addr", out_addr, 32'd4);
    drain();

    // Back-to-back stream, no bubbles
    stalls = 0;
    for (int i = 0; i < 5; i++) send(strm[i]);
    chk("stream_stalls", stalls, 32'd0);
    drain();

    // Vector table, back-to-back with rejected requests mixed in
    stalls = 0;
    for (int i = 0; i < 27; i++) send(tbl[i]);
    chk("table_stalls", stalls, 32'd0);
    drain();

    // Isolated errors: pulse, no word, address unchanged
    for (int i = 0; i < 3; i++) begin
      send(errs[i]);
      in_valid = 1'b0;
      @(negedge clk);
      chk("err_pulse", {31'd0, err_valid}, 32'd1);
      chk("err_no_word", {31'd0, out_valid}, 32'd0);
      chk("err_addr_hold", out_addr, model_addr);
      @(negedge clk);
      chk("err_pulse_end", {31'd0, err_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    drain();

    // Backpressure: word held 3 cycles, then released with a new request taken the same cycle
    out_ready = 1'b0;
    a_addr = model_addr;
    send(v_a);
    drive(v_b);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_instr", out_instr, v_a.instr);
      chk("bp_addr", out_addr, a_addr);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    stalls = 0;
    send(v_b);
    chk("bp_release_stalls", stalls, 32'd0);
    drain();

    // clear with pending word and a simultaneous request
    out_ready = 1'b0;
    send(v_c);
    drive(v_add);
    clear = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    void'(word_q.pop_back());
    model_addr = 32'd0;
    @(negedge clk);
    chk("clr_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_addr", out_addr, 32'd0);
    chk("clr_count", {16'd0, instr_count}, 32'd0);
    chk("clr_err_code_kept", {30'd0, err_code}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    drain();
    send(v_add);
    drain();

    // Mid-stream asynchronous reset
    out_ready = 1'b0;
    send(v_b);
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    chk("arst_addr", out_addr, 32'd0);
    chk("arst_err_valid", {31'd0, err_valid}, 32'd0);
    chk("arst_err_code", {30'd0, err_code}, 32'd0);
    chk("arst_count", {16'd0, instr_count}, 32'd0);
    word_q.delete();
    err_q.delete();
    model_addr = 32'd0;
    @(negedge clk);
    #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(v_add);
    drain();

    // Narrow counter: BASE_ADDR=8, ADDR_W=4 wraps 8,12,0
    begin
      logic [3:0] wexp[3];
      wexp[0] = 4'd8;
      wexp[1] = 4'd12;
      wexp[2] = 4'd0;
      out_ready2 = 1'b1;
      in_valid2  = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("wrap_valid", {31'd0, out_valid2}, 32'd1);
        chk("wrap_addr", {28'd0, out_addr2}, {28'd0, wexp[k]});
        chk("wrap_instr", out_instr2, 32'hFFF00093);
        if (k == 2) in_valid2 = 1'b0;
      end
      @(negedge clk);
      chk("wrap_done_valid", {31'd0, out_valid2}, 32'd0);
      chk("wrap_final_addr", {28'd0, out_addr2}, 32'd4);
      chk("wrap_count", {16'd0, instr_count2}, 32'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
